// File: rtl/mips_cpu_register_file_mp.sv
// Multi-read-port register file with optional write bypass, a pending-result
// scoreboard and a sequenced clear engine that zeroes one register per cycle.

module mips_cpu_register_file_mp_rd_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic [DATA_W-1:0] stored_i,
  input  logic              pend_i,
  input  logic              wr_ok_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rpend_o
);
  logic hit, zero;

  // wr_ok_i already folds in FSM idle and zero-register suppression
  assign hit  = (BYPASS != 0) && wr_ok_i && (waddr_i == raddr_i);
  assign zero = (ZERO_REG != 0) && (raddr_i == '0);

  assign rdata_o = zero ? '0 : (hit ? wdata_i : stored_i);
  assign rpend_o = pend_i & ~hit & ~zero;
endmodule

module mips_cpu_register_file_mp #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_RD    = 2,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1,
  parameter int DEBUG_REG = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rpend,
  input  logic                     pend_set,
  input  logic [ADDR_W-1:0]        pend_addr,
  input  logic                     clear_req,
  output logic                     clear_busy,
  output logic                     clear_done,
  output logic [DATA_W-1:0]        dbg_data
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH-1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic              idle, wr_ok, set_ok;
  logic [ADDR_W-1:0] cidx;

  assign idle   = (state_q == S_IDLE);
  assign wr_ok  = we & idle & ~((ZERO_REG != 0) && (waddr == '0));
  assign set_ok = pend_set & idle & ~((ZERO_REG != 0) && (pend_addr == '0));
  assign cidx   = cnt_q[ADDR_W-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (clear_req) begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A new pend_set overrides the clear from a same-cycle write to that index
  always_comb begin
    pend_d = pend_q;
    if (state_q == S_CLEAR) begin
      pend_d[cidx] = 1'b0;
    end else begin
      if (wr_ok)  pend_d[waddr]     = 1'b0;
      if (set_ok) pend_d[pend_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (state_q == S_CLEAR) begin
      regs_q[cidx] <= '0;
    end else if (wr_ok) begin
      regs_q[waddr] <= wdata;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = raddr[k*ADDR_W +: ADDR_W];
    mips_cpu_register_file_mp_rd_port #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd (
      .raddr_i (ra),
      .stored_i(regs_q[ra]),
      .pend_i  (pend_q[ra]),
      .wr_ok_i (wr_ok),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .rdata_o (rdata[k*DATA_W +: DATA_W]),
      .rpend_o (rpend[k])
    );
  end

  assign clear_busy = (state_q != S_IDLE);
  assign clear_done = (state_q == S_DONE);
  assign dbg_data   = regs_q[ADDR_W'(DEBUG_REG)];
endmodule
